// File: rtl/word_clip_sequencer.sv
// Streams one utterance from sample memory into the word clipper, filters the
// detected word segments by length and queues the survivors in a small FIFO.
module word_clip_sequencer #(
  parameter int unsigned IDX_W   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MIN_LEN = 32
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             istart,
  input  logic [IDX_W-1:0] ibase,
  input  logic [IDX_W-1:0] ilen,
  output logic             obusy,
  output logic             odone,
  output logic             omem_rd,
  output logic [IDX_W-1:0] omem_addr,
  input  logic [15:0]      imem_data,
  output logic             ocl_rstn,
  output logic             ocl_valid,
  output logic [IDX_W-1:0] ocl_idx,
  output logic [15:0]      ocl_data,
  output logic             ocl_last,
  output logic             ocl_ack,
  input  logic             icl_valid,
  input  logic [IDX_W-1:0] icl_start,
  input  logic [IDX_W-1:0] icl_end,
  output logic             oseg_valid,
  output logic [IDX_W-1:0] oseg_start,
  output logic [IDX_W-1:0] oseg_end,
  input  logic             iseg_ready,
  output logic [15:0]      oseg_count,
  output logic [15:0]      odrop_count
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  localparam logic [15:0] SAT = 16'hFFFF;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_SEG, S_TAIL, S_FIN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] s;
    logic [IDX_W-1:0] e;
  } seg_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [IDX_W-1:0] lim_q, lim_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0] pres_idx_q, pres_idx_d;
  logic [15:0]      seg_cnt_q, seg_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  seg_t             mem_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             head_vld_q, head_vld_d;
  seg_t             head_q, head_d;

  logic             push, pop, full, ack, seg_short;
  logic [IDX_W-1:0] seg_len;
  seg_t             push_seg;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == SAT) ? v : v + 16'd1;
  endfunction

  // Read side: one read per FEED cycle, data presented on the following cycle.
  assign omem_rd   = (state_q == S_FEED) && (rd_ptr_q < lim_q);
  assign omem_addr = rd_ptr_q;
  assign ocl_valid = rd_vld_q;
  assign ocl_idx   = pres_idx_q;
  assign ocl_data  = rd_vld_q ? imem_data : 16'h0000;
  assign ocl_last  = rd_vld_q && (pres_idx_q == last_q);
  assign ocl_rstn  = (state_q != S_IDLE) && (state_q != S_CLR);
  assign obusy     = (state_q != S_IDLE);
  assign odone     = (state_q == S_FIN);
  assign ocl_ack   = ack;

  assign oseg_valid  = head_vld_q;
  assign oseg_start  = head_q.s;
  assign oseg_end    = head_q.e;
  assign oseg_count  = seg_cnt_q;
  assign odrop_count = drop_cnt_q;

  assign seg_len   = icl_end - icl_start + IDX_W'(1);
  assign seg_short = (seg_len < IDX_W'(MIN_LEN));
  assign push_seg  = {icl_start, icl_end};
  assign pop       = head_vld_q && iseg_ready;
  assign full      = (cnt_q == CW'(DEPTH));

  // Control FSM. Ack is combinational so the clipper drops its segment at the
  // same edge the segment is taken, and is never seen twice.
  always_comb begin : ctrl
    state_d    = state_q;
    base_d     = base_q;
    lim_d      = lim_q;
    last_d     = last_q;
    zero_d     = zero_q;
    rd_ptr_d   = rd_ptr_q;
    seg_cnt_d  = seg_cnt_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    ack        = 1'b0;
    rd_vld_d   = omem_rd && !icl_valid;
    pres_idx_d = rd_ptr_q;
    if (omem_rd) rd_ptr_d = rd_ptr_q + IDX_W'(1);
    case (state_q)
      S_IDLE: begin
        if (istart) begin
          base_d     = ibase;
          lim_d      = ibase + ilen;
          last_d     = ibase + ilen - IDX_W'(1);
          zero_d     = (ilen == '0);
          seg_cnt_d  = 16'h0000;
          drop_cnt_d = 16'h0000;
          state_d    = S_CLR;
        end
      end
      S_CLR: begin
        rd_ptr_d = base_q;
        state_d  = zero_q ? S_FIN : S_FEED;
      end
      S_FEED: begin
        if (icl_valid)     state_d = S_SEG;
        else if (ocl_last) state_d = S_TAIL;
      end
      S_TAIL: begin
        state_d = icl_valid ? S_SEG : S_FIN;
      end
      S_SEG: begin
        if (!icl_valid) begin
          state_d = (rd_ptr_q < lim_q) ? S_FEED : S_FIN;
        end else begin
          if (seg_short) begin
            ack        = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
          end else if (!full || pop) begin
            push      = 1'b1;
            ack       = 1'b1;
            seg_cnt_d = sat_inc(seg_cnt_q);
          end
          if (ack) begin
            if (icl_end == last_q) begin
              state_d = S_FIN;
            end else begin
              rd_ptr_d = icl_end + IDX_W'(1);
              state_d  = S_FEED;
            end
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Segment FIFO bookkeeping with a registered head.
  always_comb begin : fifo_next
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    wp_d       = push ? wp_q + PW'(1) : wp_q;
    rp_d       = pop ? rp_q + PW'(1) : rp_q;
    head_vld_d = (cnt_d != '0);
    head_d     = head_q;
    if (pop) begin
      head_d = (cnt_q == CW'(1)) ? push_seg : mem_q[rp_q + PW'(1)];
    end else if (cnt_q == '0) begin
      head_d = push_seg;
    end
  end

  always_ff @(posedge iclk) begin : fifo_mem
    if (push) mem_q[wp_q] <= push_seg;
  end

  always_ff @(posedge iclk) begin : seq
    if (irst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      lim_q      <= '0;
      last_q     <= '0;
      zero_q     <= 1'b0;
      rd_ptr_q   <= '0;
      rd_vld_q   <= 1'b0;
      pres_idx_q <= '0;
      seg_cnt_q  <= '0;
      drop_cnt_q <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      lim_q      <= lim_d;
      last_q     <= last_d;
      zero_q     <= zero_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_vld_q   <= rd_vld_d;
      pres_idx_q <= pres_idx_d;
      seg_cnt_q  <= seg_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

endmodule

// File: tb/tb_word_clip_sequencer.sv
// Directed bench for word_clip_sequencer: scripted clipper stub, sample memory
// responder, and a negedge monitor feeding hand-computed checks.
module tb_word_clip_sequencer;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        istart = 1'b0;
  logic [31:0] ibase = '0;
  logic [31:0] ilen = '0;
  logic        obusy, odone, omem_rd;
  logic [31:0] omem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic        ocl_rstn, ocl_valid;
  logic [31:0] ocl_idx;
  logic [15:0] ocl_data;
  logic        ocl_last, ocl_ack;
  logic        icl_valid = 1'b0;
  logic [31:0] icl_start = '0;
  logic [31:0] icl_end = '0;
  logic        oseg_valid;
  logic [31:0] oseg_start, oseg_end;
  logic        iseg_ready = 1'b0;
  logic [15:0] oseg_count, odrop_count;

  word_clip_sequencer #(.IDX_W(32), .DEPTH(4), .MIN_LEN(32)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .ibase(ibase), .ilen(ilen),
    .obusy(obusy), .odone(odone), .omem_rd(omem_rd), .omem_addr(omem_addr),
    .imem_data(imem_data), .ocl_rstn(ocl_rstn), .ocl_valid(ocl_valid),
    .ocl_idx(ocl_idx), .ocl_data(ocl_data), .ocl_last(ocl_last), .ocl_ack(ocl_ack),
    .icl_valid(icl_valid), .icl_start(icl_start), .icl_end(icl_end),
    .oseg_valid(oseg_valid), .oseg_start(oseg_start), .oseg_end(oseg_end),
    .iseg_ready(iseg_ready), .oseg_count(oseg_count), .odrop_count(odrop_count)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample memory contents: 0x0300 inside [hs,he], fill elsewhere.
  logic [31:0] hs = 32'd1;
  logic [31:0] he = 32'd0;
  logic [15:0] fill = 16'h0000;
  function automatic logic [15:0] samp(input logic [31:0] a);
    return (a >= hs && a <= he) ? 16'h0300 : fill;
  endfunction

  logic        r_rd = 1'b0;
  logic [31:0] r_addr = '0;
  always @(negedge iclk) begin
    r_rd = omem_rd;
    r_addr = omem_addr;
  end
  always @(posedge iclk) begin
    #1;
    imem_data = r_rd ? samp(r_addr) : 16'hDEAD;
  end

  // Clipper stub: reports scripted segment k once index trig[k] is presented.
  int trig [8];
  int ss [8];
  int se [8];
  int nseg = 0;
  int sidx = 0;
  logic s_ack = 1'b0, s_val = 1'b0, s_go = 1'b0, s_rst = 1'b0;
  logic [31:0] s_idx = '0;
  always @(negedge iclk) begin
    s_ack = ocl_ack;
    s_val = ocl_valid;
    s_idx = ocl_idx;
    s_go  = istart && !obusy;
    s_rst = irst;
  end
  always @(posedge iclk) begin
    #1;
    if (s_rst) begin
      icl_valid = 1'b0;
    end else if (s_go) begin
      sidx = 0;
      icl_valid = 1'b0;
    end else if (icl_valid && s_ack) begin
      icl_valid = 1'b0;
    end else if (!icl_valid && s_val && sidx < nseg && s_idx == 32'(trig[sidx])) begin
      icl_start = 32'(ss[sidx]);
      icl_end = 32'(se[sidx]);
      icl_valid = 1'b1;
      sidx++;
    end
  end

  // Per-run monitor; statistics clear when a run is accepted.
  int n_rd, n_last, n_ack, n_done, data_err, rstn_err, has_replay;
  int last_cyc, done_cyc, start_cyc;
  logic [31:0] first_rd, last_rd, last_idx, replay_addr;
  logic after_ack = 1'b0;
  always @(negedge iclk) begin
    if (istart && !obusy) begin
      n_rd = 0; n_last = 0; n_ack = 0; n_done = 0; data_err = 0; rstn_err = 0;
      has_replay = 0; after_ack = 1'b0; start_cyc = cyc;
      first_rd = '0; last_rd = '0; last_idx = '0; replay_addr = '0;
    end
    if (omem_rd) begin
      if (n_rd == 0) first_rd = omem_addr;
      last_rd = omem_addr;
      n_rd++;
      if (after_ack) begin
        replay_addr = omem_addr;
        has_replay = 1;
        after_ack = 1'b0;
      end
    end
    if (ocl_valid) begin
      if (ocl_data !== samp(ocl_idx)) data_err++;
      if (!ocl_rstn || !obusy) rstn_err++;
    end
    if (ocl_last) begin n_last++; last_idx = ocl_idx; last_cyc = cyc; end
    if (ocl_ack) begin n_ack++; after_ack = 1'b1; end
    if (odone) begin n_done++; done_cyc = cyc; end
  end

  task automatic start_run(input logic [31:0] b, input logic [31:0] l);
    @(posedge iclk); #1;
    ibase = b; ilen = l; istart = 1'b1;
    @(posedge iclk); #1;
    istart = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int got = 0;
    for (int k = 0; k < budget && got == 0; k++) begin
      @(negedge iclk);
      if (odone) got = 1;
    end
    @(negedge iclk);
    check_eq(tag, 96'(got), 96'd1);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] s, input logic [31:0] e);
    @(negedge iclk);
    check_eq(tag, oseg_valid ? {oseg_start, oseg_end} : {64{1'b1}}, {s, e});
    @(posedge iclk); #1 iseg_ready = 1'b1;
    @(posedge iclk); #1 iseg_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    repeat (3) @(posedge iclk);
    #1 irst = 1'b0;
    @(negedge iclk);
    check_eq("rst_outs", {obusy, odone, omem_rd, ocl_valid, ocl_last, ocl_ack, oseg_valid, ocl_rstn}, 96'h0);
    check_eq("rst_cnts", {oseg_count, odrop_count}, 96'h0);

    // Plain run, no words; a second istart while busy must be ignored.
    fill = 16'h0010; nseg = 0;
    start_run(32'h100, 32'd8);
    repeat (2) @(posedge iclk);
    #1 ibase = 32'h500; ilen = 32'd3; istart = 1'b1;
    @(posedge iclk); #1 istart = 1'b0;
    wait_done("t1_done", 200);
    check_eq("t1_nrd", 96'(n_rd), 96'd8);
    check_eq("t1_rd_span", {first_rd, last_rd}, {32'h100, 32'h107});
    check_eq("t1_last", {32'(n_last), last_idx}, {32'd1, 32'h107});
    check_eq("t1_ack", 96'(n_ack), 96'd0);
    check_eq("t1_done_lat", 96'(done_cyc - last_cyc), 96'd2);
    check_eq("t1_cnts", {oseg_count, odrop_count}, 96'h0);
    check_eq("t1_data_rstn", {32'(data_err), 32'(rstn_err)}, 96'h0);

    // One long word with replay.
    fill = 16'h0000; hs = 32'd50; he = 32'd149;
    nseg = 1; trig[0] = 151; ss[0] = 50; se[0] = 150;
    start_run(32'd0, 32'd200);
    wait_done("t2_done", 1000);
    check_eq("t2_ack", 96'(n_ack), 96'd1);
    check_eq("t2_replay", {32'(has_replay), replay_addr}, {32'd1, 32'd151});
    check_eq("t2_cnts", {oseg_count, odrop_count}, {16'd1, 16'd0});
    check_eq("t2_last", {last_idx, 32'(done_cyc - last_cyc)}, {32'd199, 32'd2});
    check_eq("t2_data", 96'(data_err), 96'd0);
    pop_check("t2_head", 32'd50, 32'd150);
    @(negedge iclk);
    check_eq("t2_empty", 96'(oseg_valid), 96'd0);

    // Short word is dropped.
    hs = 32'd10; he = 32'd20;
    nseg = 1; trig[0] = 21; ss[0] = 10; se[0] = 20;
    start_run(32'd0, 32'd40);
    wait_done("t3_done", 500);
    check_eq("t3_cnts", {oseg_count, odrop_count}, {16'd0, 16'd1});
    check_eq("t3_ack_replay", {32'(n_ack), 32'(has_replay), replay_addr}, {32'd1, 32'd1, 32'd21});
    check_eq("t3_novalid", 96'(oseg_valid), 96'd0);

    // Five long words into a 4-deep FIFO with no consumer.
    hs = 32'd1; he = 32'd0; fill = 16'h0007; nseg = 5;
    for (int k = 0; k < 5; k++) begin
      trig[k] = 50 * k + 50; ss[k] = 50 * k + 10; se[k] = 50 * k + 49;
    end
    start_run(32'd0, 32'd300);
    got = 0;
    for (int k = 0; k < 2000 && got == 0; k++) begin
      @(negedge iclk);
      if (sidx == 5 && icl_valid) got = 1;
    end
    check_eq("t4_reach5", 96'(got), 96'd1);
    repeat (3) @(negedge iclk);
    check_eq("t4_hold", {ocl_ack, omem_rd, obusy, oseg_count}, {1'b0, 1'b0, 1'b1, 16'd4});
    @(posedge iclk); #1 iseg_ready = 1'b1;
    @(negedge iclk);
    check_eq("t4_pop_push", {ocl_ack, oseg_start, oseg_end}, {1'b1, 32'd10, 32'd49});
    @(posedge iclk); #1 iseg_ready = 1'b0;
    wait_done("t4_done", 1000);
    check_eq("t4_cnts", {oseg_count, odrop_count, 32'(data_err)}, {16'd5, 16'd0, 32'd0});
    for (int k = 1; k < 5; k++) pop_check("t4_drain", 32'(ss[k]), 32'(se[k]));
    @(negedge iclk);
    check_eq("t4_empty", 96'(oseg_valid), 96'd0);

    // Word still active at the final sample: no replay.
    fill = 16'h0000; hs = 32'd20; he = 32'd63;
    nseg = 1; trig[0] = 63; ss[0] = 20; se[0] = 63;
    start_run(32'd0, 32'd64);
    wait_done("t5_done", 500);
    check_eq("t5_rd", {32'(n_rd), 32'(has_replay), 32'(n_ack)}, {32'd64, 32'd0, 32'd1});
    check_eq("t5_cnt", 96'(oseg_count), 96'd1);
    @(negedge iclk);
    check_eq("t5_head", {oseg_valid, oseg_start, oseg_end}, {1'b1, 32'd20, 32'd63});

    // Empty run.
    nseg = 0;
    start_run(32'h55, 32'd0);
    wait_done("t6_done", 50);
    check_eq("t6_lat", 96'(done_cyc - start_cyc), 96'd2);
    check_eq("t6_nrd", 96'(n_rd), 96'd0);
    check_eq("t6_state", {oseg_valid, oseg_count, odrop_count}, {1'b1, 16'd0, 16'd0});

    // Reset in the middle of FEED.
    hs = 32'd1; he = 32'd0; fill = 16'h0022;
    start_run(32'h300, 32'd100);
    repeat (10) @(negedge iclk);
    check_eq("t7_feeding", {omem_rd, ocl_rstn}, {1'b1, 1'b1});
    @(posedge iclk); #1 irst = 1'b1;
    @(posedge iclk); #1 irst = 1'b0;
    @(negedge iclk);
    check_eq("t7_rst_outs", {obusy, odone, omem_rd, ocl_valid, ocl_last, ocl_ack, oseg_valid, ocl_rstn}, 96'h0);
    check_eq("t7_rst_cnts", {oseg_count, odrop_count}, 96'h0);
    repeat (20) @(negedge iclk);
    check_eq("t7_no_done", 96'(n_done), 96'd0);
    start_run(32'h20, 32'd8);
    wait_done("t7_rerun_done", 200);
    check_eq("t7_rerun", {32'(n_rd), first_rd, 32'(data_err)}, {32'd8, 32'h20, 32'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
